// File: rtl/gray_pkg.sv
// Shared FSM state encoding and Gray-to-binary conversion for the Gray step decoder.
package gray_pkg;

    typedef enum logic {
        StInit  = 1'b0,
        StTrack = 1'b1
    } state_e;

    localparam int unsigned MaxGw = 8;

    // Narrower codes are zero-extended, which leaves the low bits of the result unchanged.
    function automatic logic [MaxGw-1:0] gray2bin(input logic [MaxGw-1:0] g);
        logic [MaxGw-1:0] b;
        b[MaxGw-1] = g[MaxGw-1];
        for (int i = MaxGw - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of width GW (2..8).
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned GW = 3
) (
    input  logic [GW-1:0] gray,
    output logic [GW-1:0] bin
);

    assign bin = GW'(gray2bin(MaxGw'(gray)));

endmodule

// File: rtl/gray_step_decoder.sv
// Tracks a Gray-coded position, emitting +1/-1 step pulses, a signed count and a sticky error.
// Define GRAY_STEP_DECODER_SYNC_EN to pass gin through a two-flop synchronizer first.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int unsigned GW = 3,
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [GW-1:0] gin,
    input  logic          clr_err,
    output logic [GW-1:0] bin,
    output logic [PW-1:0] pos,
    output logic          step_up,
    output logic          step_dn,
    output logic          err
);

    logic [GW-1:0] gsamp;
    logic          samp_vld;

`ifdef GRAY_STEP_DECODER_SYNC_EN
    logic [GW-1:0] sync1;
    logic [GW-1:0] sync2;
    logic [1:0]    vld_q;

    // Hold off the baseline until a real sample has reached the end of the synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            vld_q <= '0;
        end else begin
            sync1 <= gin;
            sync2 <= sync1;
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    assign gsamp    = sync2;
    assign samp_vld = vld_q[1];
`else
    assign gsamp    = gin;
    assign samp_vld = 1'b1;
`endif

    logic [GW-1:0] new_bin;
    logic [GW-1:0] delta;
    logic          is_up;
    logic          is_dn;
    logic          is_bad;

    gray_to_bin #(
        .GW(GW)
    ) u_conv (
        .gray(gsamp),
        .bin (new_bin)
    );

    always_comb begin
        delta  = new_bin - bin;
        is_up  = (delta == GW'(1));
        is_dn  = (delta == '1);
        is_bad = (delta != '0) && !is_up && !is_dn;
    end

    state_e state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StInit;
            bin     <= '0;
            pos     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            case (state)
                StInit: begin
                    err <= err & ~clr_err;
                    if (samp_vld) begin
                        bin   <= new_bin;
                        state <= StTrack;
                    end
                end
                StTrack: begin
                    bin <= new_bin;
                    // An illegal jump wins over a coincident clear.
                    err <= is_bad | (err & ~clr_err);
                    if (is_up) begin
                        pos     <= pos + PW'(1);
                        step_up <= 1'b1;
                    end else if (is_dn) begin
                        pos     <= pos - PW'(1);
                        step_dn <= 1'b1;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Self-checking bench for gray_step_decoder: vector table through a scoreboard plus latency checks.
module tb_gray_step_decoder;

`ifdef GRAY_STEP_DECODER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] gin = 3'b000;
    logic       clr_err = 1'b0;
    logic [2:0] bin;
    logic [7:0] pos;
    logic       step_up;
    logic       step_dn;
    logic       err;

    gray_step_decoder #(
        .GW(3),
        .PW(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .gin    (gin),
        .clr_err(clr_err),
        .bin    (bin),
        .pos    (pos),
        .step_up(step_up),
        .step_dn(step_dn),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [2:0] g;
        logic [2:0] b;
        logic [7:0] p;
        logic       up;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic clr, input logic [2:0] g,
                                input logic [2:0] b, input logic [7:0] p,
                                input logic up, input logic dn, input logic er);
        vec_t v;
        v.rst = rst; v.clr = clr; v.g = g; v.b = b; v.p = p;
        v.up = up; v.dn = dn; v.er = er;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t e;
        int   n;
        // rst clr gin     bin     pos    up dn err
        add(1, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b001, 3'd1, 8'h01, 1, 0, 0);
        add(0, 0, 3'b011, 3'd2, 8'h02, 1, 0, 0);
        add(0, 0, 3'b010, 3'd3, 8'h03, 1, 0, 0);
        add(0, 0, 3'b110, 3'd4, 8'h04, 1, 0, 0);
        add(0, 0, 3'b111, 3'd5, 8'h05, 1, 0, 0);
        add(0, 0, 3'b101, 3'd6, 8'h06, 1, 0, 0);
        add(0, 0, 3'b100, 3'd7, 8'h07, 1, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h08, 1, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h08, 0, 0, 0);
        add(1, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b100, 3'd7, 8'hFF, 0, 1, 0);
        add(0, 0, 3'b000, 3'd0, 8'h00, 1, 0, 0);
        add(0, 0, 3'b011, 3'd2, 8'h00, 0, 0, 1);
        add(0, 0, 3'b011, 3'd2, 8'h00, 0, 0, 1);
        add(0, 0, 3'b010, 3'd3, 8'h01, 1, 0, 1);
        add(0, 1, 3'b101, 3'd6, 8'h01, 0, 0, 1);
        add(0, 1, 3'b101, 3'd6, 8'h01, 0, 0, 0);
        add(0, 0, 3'b100, 3'd7, 8'h02, 1, 0, 0);
        add(0, 0, 3'b101, 3'd6, 8'h01, 0, 1, 0);
        add(0, 0, 3'b100, 3'd7, 8'h02, 1, 0, 0);
        add(0, 0, 3'b000, 3'd0, 8'h03, 1, 0, 0);
        add(0, 0, 3'b001, 3'd1, 8'h04, 1, 0, 0);
        add(0, 0, 3'b011, 3'd2, 8'h05, 1, 0, 0);
        add(0, 0, 3'b111, 3'd5, 8'h05, 0, 0, 1);
        add(1, 1, 3'b010, 3'd0, 8'h00, 0, 0, 0);
        add(0, 0, 3'b110, 3'd4, 8'h00, 0, 0, 0);
        add(0, 0, 3'b111, 3'd5, 8'h01, 1, 0, 0);

        // Each vector is held for LAT edges so it has fully propagated when checked.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset   = vecs[i].rst;
            clr_err = vecs[i].clr;
            gin     = vecs[i].g;
            exp_q.push_back(vecs[i]);
            repeat (LAT) @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bin !== e.b || pos !== e.p || step_up !== e.up || step_dn !== e.dn ||
                err !== e.er || (step_up && step_dn)) begin
                n_fail++;
                $display("FAIL vec%0d: got bin=%b pos=%h up=%b dn=%b err=%b, want bin=%b pos=%h up=%b dn=%b err=%b",
                         i, bin, pos, step_up, step_dn, err, e.b, e.p, e.up, e.dn, e.er);
            end
        end

        // Latency of a single +1 step from a fresh baseline.
        @(negedge clk);
        reset   = 1'b1;
        clr_err = 1'b0;
        gin     = 3'b000;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        gin = 3'b001;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (step_up) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n != LAT) begin
            n_fail++;
            $display("FAIL latency: got %0d edges (0 = timeout), want %0d", n, LAT);
        end

        // The pulse lasts exactly one cycle and the count settles at 1.
        @(posedge clk);
        #1;
        n_checks++;
        if (step_up !== 1'b0 || step_dn !== 1'b0 || pos !== 8'h01 || bin !== 3'd1) begin
            n_fail++;
            $display("FAIL pulse_width: got up=%b dn=%b pos=%h bin=%b, want up=0 dn=0 pos=01 bin=001",
                     step_up, step_dn, pos, bin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
